fpnew_lane_iter_divsqrt: RTL and testbench
==========================================

Name: fpnew_lane_iter_divsqrt

Overview:
- Per-lane iterative radix-2 integer divide / square-root datapath that sits directly downstream of the shared FPU aux FSM chain.
- Consumes one bit of that chain's per-lane FSM start vector and returns one bit of its per-lane FSM ready vector.
- Holds its result stable until the next start, so the aux chain can stall indefinitely in its hold state.
- One instance per SIMD lane. Mantissa pre/post-processing (normalisation, rounding) is outside this block.

Parameters:
- Width, 8, operand/result width in bits; must be even and >= 4.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  single-cycle start pulse; operands are sampled in the same cycle.
- flush_i  in  1  synchronous abort of any operation in flight.
- op_sqrt_i  in  1  0 = divide a/b, 1 = square root of a; sampled with start_i.
- a_i  in  Width  dividend / radicand; sampled with start_i.
- b_i  in  Width  divisor; sampled with start_i, ignored for sqrt.
- ready_o  out  1  high whenever no computation is running; held continuously.
- busy_o  out  1  high while iterating (equals ~ready_o).
- quot_o  out  Width  quotient or root.
- rem_o  out  Width  remainder (div: a mod b; sqrt: a - q*q, zero-extended).
- div_by_zero_o  out  1  last divide had b == 0.
- inexact_o  out  1  rem_o != 0.

Behaviour:
- Reset (rst_i high at an edge):
  - state goes to IDLE; ready_o=1, busy_o=0.
  - quot_o, rem_o, div_by_zero_o and inexact_o are all 0.
  - Reset overrides start_i and flush_i, including mid-operation.
- States: IDLE, ITER, DONE. ready_o=1 in IDLE and DONE; 0 in ITER.
- Start (start_i=1 while not flushing, from any state, including ITER, which aborts and restarts):
  - Capture a_i, b_i and op_sqrt_i.
  - Load iteration counter N (Width for div, Width/2 for sqrt).
  - Clear the partial remainder; go to ITER.
  - ready_o is low from cycle T+1 when start is asserted in cycle T.
- Divide by zero (divide with b_i == 0):
  - No iteration; next state is DONE at T+1.
  - quot_o=all ones, rem_o=a_i, div_by_zero_o=1, inexact_o=(a_i!=0).
- Divide iteration (restoring):
  - Partial remainder is Width+1 bits. Each cycle: shift left and append the next dividend MSB; if result >= b, subtract b and shift in quotient bit 1, else shift in 0.
- Sqrt iteration (digit-by-digit):
  - Partial remainder is Width/2+2 bits. Each cycle consumes two radicand bits.
  - Trial value = (root<<2)|1; if rem >= trial, subtract and append root bit 1, else append 0.
- Counter and completion:
  - Counter decrements once per ITER cycle; when it reaches 0, go to DONE.
  - Latency: ready_o rises in cycle T+Width (div) or T+Width/2 (sqrt).
  - Outputs update in the same cycle ready_o rises; they are stable in DONE and IDLE until the next completion.
- Outputs during ITER:
  - quot_o, rem_o and the flags keep the previous completed result.
  - Internal working registers are separate from the output registers.
- Flush:
  - flush_i=1 forces IDLE at the next edge; ready_o=1 from T+1.
  - Output registers are not modified.
  - flush_i has priority over a simultaneous start_i (the start is dropped).
- start_i while already in DONE is the normal back-to-back case, with no idle bubble required.
- No state leaves DONE except start, flush or reset. DONE and IDLE are output-equivalent; DONE exists to distinguish "result present" for assertions.
- All arithmetic is unsigned; no signed mode.

Test Plan:
- Width=8, start at T with div a=200, b=7: ready_o=0 on T+1..T+7, ready_o=1 at T+8, quot_o=28, rem_o=4, inexact_o=1, div_by_zero_o=0.
- Sqrt a=200: ready_o=1 at T+4, quot_o=14, rem_o=4, inexact_o=1. Second run with sqrt a=144 gives quot_o=12, rem_o=0, inexact_o=0.
- Div a=0x55, b=0: ready_o=1 at T+1, quot_o=0xFF, rem_o=0x55, div_by_zero_o=1, inexact_o=1.
- Div 255/1 completes (quot_o=255, rem_o=0). A new div 9/3 starts in a DONE cycle: ready_o=0 the next cycle, quot_o stays 255 until T+8, then quot_o=3, rem_o=0.
- Start div 100/9, assert flush_i at T+3 together with a start: IDLE at T+4, ready_o=1, outputs unchanged from the prior result, no completion seen afterwards.
- Start div, assert rst_i at T+2: at T+3 ready_o=1, quot_o=0, rem_o=0, flags 0. Random compare of 10k div/sqrt ops against a reference model, with an assertion that busy_o==~ready_o at all times.

Source files
------------

// File: rtl/fpnew_lane_iter_divsqrt.sv
// Per-lane iterative radix-2 unsigned divide / square-root unit.
// Restoring division retires one quotient bit per step. Digit-by-digit square
// root retires one root bit per step, consuming two radicand bits each time.
// The first step is folded into the start edge, so a divide takes Width edges
// and a square root takes Width/2 edges from start to ready.
// The output registers are written only when an operation completes, so the
// last result stays visible while the next operation runs, after a flush, and
// while the upstream aux chain holds.
module fpnew_lane_iter_divsqrt #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic             op_sqrt_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic [Width-1:0] quot_o,
  output logic [Width-1:0] rem_o,
  output logic             div_by_zero_o,
  output logic             inexact_o
);

  localparam int HalfW = Width / 2;
  localparam int SqW   = HalfW + 2;
  localparam int CntW  = $clog2(Width + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Width-1:0]  rem_q;
  logic [Width-1:0]  src_q;
  logic [Width-2:0]  quot_q;
  logic [Width-1:0]  b_q;
  logic              sqrt_q;

  logic [Width-1:0]  rem_in, src_in, b_in;
  logic [Width-2:0]  quot_in;
  logic              sqrt_in;
  logic [Width:0]    div_shift;
  logic              div_ge;
  logic [SqW-1:0]    sq_shift, sq_trial;
  logic              sq_ge;
  logic [Width-1:0]  rem_nxt, src_nxt;
  logic [Width-1:0]  quot_nxt;

  logic load_work, adv_work, finish, dbz_finish;

  // One iteration step, fed from the live operands on a start edge and from
  // the working registers otherwise.
  always_comb begin
    rem_in    = start_i ? '0 : rem_q;
    src_in    = start_i ? a_i : src_q;
    quot_in   = start_i ? '0 : quot_q;
    b_in      = start_i ? b_i : b_q;
    sqrt_in   = start_i ? op_sqrt_i : sqrt_q;
    div_shift = {rem_in, src_in[Width-1]};
    div_ge    = div_shift >= {1'b0, b_in};
    sq_shift  = {rem_in[HalfW-1:0], src_in[Width-1 -: 2]};
    sq_trial  = {quot_in[HalfW-1:0], 2'b01};
    sq_ge     = sq_shift >= sq_trial;
    if (sqrt_in) begin
      rem_nxt  = Width'(sq_ge ? (sq_shift - sq_trial) : sq_shift);
      src_nxt  = src_in << 2;
      quot_nxt = {quot_in, sq_ge};
    end else begin
      rem_nxt  = div_ge ? (div_shift[Width-1:0] - b_in) : div_shift[Width-1:0];
      src_nxt  = src_in << 1;
      quot_nxt = {quot_in, div_ge};
    end
  end

  // Next-state and control decode: flush beats start, and start beats iteration.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_work  = 1'b0;
    adv_work   = 1'b0;
    finish     = 1'b0;
    dbz_finish = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else if (start_i) begin
      if (!op_sqrt_i && (b_i == '0)) begin
        state_d    = DONE;
        dbz_finish = 1'b1;
      end else begin
        state_d   = ITER;
        load_work = 1'b1;
        cnt_d     = op_sqrt_i ? CntW'(HalfW - 1) : CntW'(Width - 1);
      end
    end else if (state_q == ITER) begin
      adv_work = 1'b1;
      cnt_d    = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        state_d = DONE;
        finish  = 1'b1;
      end
    end
  end

  // State and iteration counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Working registers, kept apart from the outputs so the previous result holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      src_q  <= '0;
      quot_q <= '0;
      b_q    <= '0;
      sqrt_q <= 1'b0;
    end else begin
      if (load_work || adv_work) begin
        rem_q  <= rem_nxt;
        src_q  <= src_nxt;
        quot_q <= quot_nxt[Width-2:0];
      end
      if (load_work) begin
        b_q    <= b_i;
        sqrt_q <= op_sqrt_i;
      end
    end
  end

  // Result registers, written only when an operation completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quot_o        <= '0;
      rem_o         <= '0;
      div_by_zero_o <= 1'b0;
      inexact_o     <= 1'b0;
    end else if (dbz_finish) begin
      quot_o        <= '1;
      rem_o         <= a_i;
      div_by_zero_o <= 1'b1;
      inexact_o     <= (a_i != '0);
    end else if (finish) begin
      quot_o        <= quot_nxt;
      rem_o         <= rem_nxt;
      div_by_zero_o <= 1'b0;
      inexact_o     <= (rem_nxt != '0);
    end
  end

  assign ready_o = (state_q != ITER);
  assign busy_o  = (state_q == ITER);

endmodule

// File: tb/tb_fpnew_lane_iter_divsqrt.sv
// Self-checking bench for fpnew_lane_iter_divsqrt (Width = 8).
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_fpnew_lane_iter_divsqrt;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       flush = 1'b0;
  logic       op_sqrt = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       ready, busy, dbz, inexact;
  logic [7:0] quot, rem;

  int vectors = 0;
  int miscompares = 0;
  logic mon_on = 1'b0;

  logic [7:0] hold_q = '0;
  logic [7:0] hold_r = '0;
  logic       hold_dbz = 1'b0;
  logic       hold_inex = 1'b0;

  typedef struct {
    string      name;
    logic       op_sqrt;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       inex;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  fpnew_lane_iter_divsqrt #(.Width(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .flush_i(flush),
    .op_sqrt_i(op_sqrt),
    .a_i(a),
    .b_i(b),
    .ready_o(ready),
    .busy_o(busy),
    .quot_o(quot),
    .rem_o(rem),
    .div_by_zero_o(dbz),
    .inexact_o(inexact)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // busy must always be the complement of ready.
  always @(negedge clk) begin
    if (mon_on) begin
      vectors++;
      if (busy !== ~ready) begin
        miscompares++;
        $display("[TB] FAIL busy_vs_ready: busy=%b ready=%b", busy, ready);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, got, want);
    end
  endtask

  // One-cycle start pulse; returns in cycle T+1.
  task automatic applyStimulus(input logic s, input logic [7:0] va, input logic [7:0] vb);
    start   = 1'b1;
    op_sqrt = s;
    a       = va;
    b       = vb;
    tick();
    start = 1'b0;
  endtask

  task automatic checkHeld(input string name);
    checkOutput({name, "_quot_hold"}, quot, hold_q);
    checkOutput({name, "_rem_hold"}, rem, hold_r);
    checkOutput({name, "_dbz_hold"}, dbz, hold_dbz);
    checkOutput({name, "_inex_hold"}, inexact, hold_inex);
  endtask

  // Reference model from the arithmetic definitions.
  task automatic refModel(input logic s, input logic [7:0] va, input logic [7:0] vb,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic d, output logic x, output int lat);
    int ia, ib, iq;
    ia = va;
    ib = vb;
    if (s) begin
      iq = 0;
      while ((iq + 1) * (iq + 1) <= ia) iq++;
      q = 8'(iq);
      r = 8'(ia - iq * iq);
      d = 1'b0;
      lat = 4;
    end else if (ib == 0) begin
      q = 8'hFF;
      r = va;
      d = 1'b1;
      lat = 1;
    end else begin
      q = 8'(ia / ib);
      r = 8'(ia % ib);
      d = 1'b0;
      lat = 8;
    end
    x = (r != 8'd0);
  endtask

  task automatic runVector(input vec_t v);
    applyStimulus(v.op_sqrt, v.a, v.b);
    for (int k = 1; k < v.lat; k++) begin
      checkOutput({v.name, "_ready_low"}, ready, 1'b0);
      checkOutput({v.name, "_quot_hold"}, quot, hold_q);
      tick();
    end
    checkOutput({v.name, "_ready"}, ready, 1'b1);
    checkOutput({v.name, "_quot"}, quot, v.q);
    checkOutput({v.name, "_rem"}, rem, v.r);
    checkOutput({v.name, "_dbz"}, dbz, v.dbz);
    checkOutput({v.name, "_inex"}, inexact, v.inex);
    hold_q    = v.q;
    hold_r    = v.r;
    hold_dbz  = v.dbz;
    hold_inex = v.inex;
  endtask

  initial begin
    vecs[0] = '{"div200_7",  1'b0, 8'd200, 8'd7,   8'd28,  8'd4,    1'b0, 1'b1, 8};
    vecs[1] = '{"sqrt200",   1'b1, 8'd200, 8'd0,   8'd14,  8'd4,    1'b0, 1'b1, 4};
    vecs[2] = '{"sqrt144",   1'b1, 8'd144, 8'd99,  8'd12,  8'd0,    1'b0, 1'b0, 4};
    vecs[3] = '{"div55_0",   1'b0, 8'h55,  8'd0,   8'hFF,  8'h55,   1'b1, 1'b1, 1};
    vecs[4] = '{"div255_1",  1'b0, 8'd255, 8'd1,   8'd255, 8'd0,    1'b0, 1'b0, 8};
    vecs[5] = '{"div9_3",    1'b0, 8'd9,   8'd3,   8'd3,   8'd0,    1'b0, 1'b0, 8};
    vecs[6] = '{"sqrt255",   1'b1, 8'd255, 8'd0,   8'd15,  8'd30,   1'b0, 1'b1, 4};
    vecs[7] = '{"div7_200",  1'b0, 8'd7,   8'd200, 8'd0,   8'd7,    1'b0, 1'b1, 8};
    vecs[8] = '{"sqrt0",     1'b1, 8'd0,   8'd0,   8'd0,   8'd0,    1'b0, 1'b0, 4};
    vecs[9] = '{"div0_0",    1'b0, 8'd0,   8'd0,   8'hFF,  8'd0,    1'b1, 1'b0, 1};

    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mon_on = 1'b1;
    checkOutput("reset_ready", ready, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkHeld("reset");

    // Directed table, issued back to back from the DONE cycle.
    foreach (vecs[i]) runVector(vecs[i]);

    // Flush with a simultaneous start at T+3 drops both operations.
    applyStimulus(1'b0, 8'd100, 8'd9);
    tick();
    tick();
    flush = 1'b1;
    start = 1'b1;
    a     = 8'd3;
    b     = 8'd1;
    tick();
    flush = 1'b0;
    start = 1'b0;
    checkOutput("flush_ready", ready, 1'b1);
    checkHeld("flush");
    for (int k = 0; k < 12; k++) begin
      checkOutput("flush_idle_ready", ready, 1'b1);
      checkOutput("flush_idle_quot", quot, hold_q);
      tick();
    end
    checkHeld("flush_after");

    // Reset in the middle of a divide.
    applyStimulus(1'b0, 8'd200, 8'd7);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold_q = '0;
    hold_r = '0;
    hold_dbz = 1'b0;
    hold_inex = 1'b0;
    checkOutput("midrst_ready", ready, 1'b1);
    checkOutput("midrst_busy", busy, 1'b0);
    checkHeld("midrst");

    // Randomized operations against the reference model.
    for (int i = 0; i < 10000; i++) begin
      logic       s, ed, ex;
      logic [7:0] ra, rb, eq, er;
      int         elat, cnt;
      s  = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      refModel(s, ra, rb, eq, er, ed, ex, elat);
      applyStimulus(s, ra, rb);
      cnt = 1;
      while (ready !== 1'b1 && cnt < 20) begin
        tick();
        cnt++;
      end
      checkOutput("rand_latency", cnt, elat);
      checkOutput("rand_quot", quot, eq);
      checkOutput("rand_rem", rem, er);
      checkOutput("rand_dbz", dbz, ed);
      checkOutput("rand_inex", inexact, ex);
    end

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
